// File: rtl/fk_pkg.sv
// Shared types, constants and helpers for the forward-kinematics chain.
package fk_pkg;

  localparam int unsigned ELEM_W = 27;
  localparam int unsigned PROD_W = 2 * ELEM_W;
  localparam int unsigned SUM_W  = PROD_W + 2;

  localparam logic signed [SUM_W-1:0] ELEM_MAX = 56'sd67108863;
  localparam logic signed [SUM_W-1:0] ELEM_MIN = -56'sd67108864;

  typedef logic signed [ELEM_W-1:0] elem_t;
  typedef elem_t [3:0][3:0] mat4_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_T,
    MUL,
    DONE
  } state_t;

  function automatic mat4_t identity_mat(input int unsigned frac_bits);
    mat4_t m;
    elem_t one;
    one     = elem_t'(1) << frac_bits;
    m       = '0;
    m[0][0] = one;
    m[1][1] = one;
    m[2][2] = one;
    m[3][3] = one;
    return m;
  endfunction

endpackage

// File: rtl/fk_dot4.sv
// Combinational 4-term fixed-point dot product with floor shift and narrowing.
// FK_CHAIN_SAT_EN selects saturating narrowing (with o_sat) instead of wrap.
module fk_dot4
  import fk_pkg::*;
#(
  parameter int unsigned FRAC_BITS = 16
) (
  input  logic [3:0][ELEM_W-1:0] i_row,
  input  logic [3:0][ELEM_W-1:0] i_col,
`ifdef FK_CHAIN_SAT_EN
  output logic                   o_sat,
`endif
  output logic [ELEM_W-1:0]      o_elem
);

  logic signed [SUM_W-1:0] w_sum;

  always_comb begin
    logic signed [PROD_W-1:0] w_prod;
    w_sum = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      w_prod = PROD_W'($signed(i_row[k])) * PROD_W'($signed(i_col[k]));
      w_sum  = w_sum + SUM_W'(w_prod);
    end
  end

`ifdef FK_CHAIN_SAT_EN
  logic signed [SUM_W-1:0] w_shift;
  assign w_shift = w_sum >>> FRAC_BITS;

  always_comb begin
    o_sat  = 1'b0;
    o_elem = w_shift[ELEM_W-1:0];
    if (w_shift > ELEM_MAX) begin
      o_sat  = 1'b1;
      o_elem = 27'h3FFFFFF;
    end else if (w_shift < ELEM_MIN) begin
      o_sat  = 1'b1;
      o_elem = 27'h4000000;
    end
  end
`else
  assign o_elem = ELEM_W'(w_sum >>> FRAC_BITS);
`endif

endmodule

// File: rtl/fk_chain.sv
// Forward-kinematics chain: accumulates pose = T1*T2*...*TN, one element per cycle.
// FK_CHAIN_SAT_EN enables saturating arithmetic and the sticky ovf output.
module fk_chain
  import fk_pkg::*;
#(
  parameter int unsigned N_JOINTS  = 6,
  parameter int unsigned FRAC_BITS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   t_valid,
  output logic                   t_ready,
  input  logic [3:0][3:0][26:0]  t_matrix,
  output logic                   busy,
  output logic                   done,
`ifdef FK_CHAIN_SAT_EN
  output logic                   ovf,
`endif
  output logic [3:0][3:0][26:0]  pose
);

  state_t      r_state;
  mat4_t       r_a;
  mat4_t       r_b;
  mat4_t       r_c;
  logic [4:0]  r_idx;
  logic [3:0]  r_cnt;
  logic        r_t_ready;
  logic        r_busy;
  logic        r_done;

  logic [3:0][ELEM_W-1:0] w_row;
  logic [3:0][ELEM_W-1:0] w_col;
  logic [ELEM_W-1:0]      w_elem;
  logic [4:0]             w_cnt_nxt;

  assign w_row     = r_a[r_idx[3:2]];
  assign w_col[0]  = r_b[0][r_idx[1:0]];
  assign w_col[1]  = r_b[1][r_idx[1:0]];
  assign w_col[2]  = r_b[2][r_idx[1:0]];
  assign w_col[3]  = r_b[3][r_idx[1:0]];
  assign w_cnt_nxt = {1'b0, r_cnt} + 5'd1;

`ifdef FK_CHAIN_SAT_EN
  logic r_ovf;
  logic w_sat;

  fk_dot4 #(.FRAC_BITS(FRAC_BITS)) u_dot4 (
    .i_row  (w_row),
    .i_col  (w_col),
    .o_sat  (w_sat),
    .o_elem (w_elem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_ovf <= 1'b0;
    end else if (r_state == MUL && !r_idx[4] && w_sat) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`else
  fk_dot4 #(.FRAC_BITS(FRAC_BITS)) u_dot4 (
    .i_row  (w_row),
    .i_col  (w_col),
    .o_elem (w_elem)
  );
`endif

  // MUL runs 17 cycles: r_idx 0..15 fills C, r_idx 16 commits C into A.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_c       <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_t_ready <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a       <= identity_mat(FRAC_BITS);
            r_cnt     <= '0;
            r_t_ready <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= WAIT_T;
          end
        end
        WAIT_T: begin
          if (t_valid) begin
            r_b       <= t_matrix;
            r_idx     <= '0;
            r_t_ready <= 1'b0;
            r_state   <= MUL;
          end
        end
        MUL: begin
          if (!r_idx[4]) begin
            r_c[r_idx[3:2]][r_idx[1:0]] <= w_elem;
            r_idx <= r_idx + 5'd1;
          end else begin
            r_a   <= r_c;
            r_cnt <= w_cnt_nxt[3:0];
            if (w_cnt_nxt < 5'(N_JOINTS)) begin
              r_t_ready <= 1'b1;
              r_state   <= WAIT_T;
            end else begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign t_ready = r_t_ready;
  assign busy    = r_busy;
  assign done    = r_done;
  assign pose    = r_a;

endmodule

// File: tb/tb_fk_chain.sv
// Directed bench for fk_chain: N_JOINTS=2 and N_JOINTS=4 instances share the inputs.
module tb_fk_chain;

  typedef logic [3:0][3:0][26:0] mat_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic t_valid = 1'b0;
  mat_t t_matrix = '0;

  logic r2, b2, d2, r4, b4, d4;
  mat_t p2, p4;
`ifdef FK_CHAIN_SAT_EN
  logic ovf2, ovf4;
`endif

  int n_cmp = 0;
  int n_err = 0;
  time t_acc = 0;
  time t_first = 0;
  time t_evt = 0;

  always #5 clk = ~clk;

  fk_chain #(.N_JOINTS(2), .FRAC_BITS(16)) u_n2 (
    .clk(clk), .reset(reset), .start(start), .t_valid(t_valid), .t_ready(r2),
    .t_matrix(t_matrix), .busy(b2), .done(d2),
`ifdef FK_CHAIN_SAT_EN
    .ovf(ovf2),
`endif
    .pose(p2)
  );

  fk_chain #(.N_JOINTS(4), .FRAC_BITS(16)) u_n4 (
    .clk(clk), .reset(reset), .start(start), .t_valid(t_valid), .t_ready(r4),
    .t_matrix(t_matrix), .busy(b4), .done(d4),
`ifdef FK_CHAIN_SAT_EN
    .ovf(ovf4),
`endif
    .pose(p4)
  );

  task automatic chk(input string tag, input logic [431:0] obs, input logic [431:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic mat_t ident();
    mat_t m = '0;
    m[0][0] = 27'h10000; m[1][1] = 27'h10000; m[2][2] = 27'h10000; m[3][3] = 27'h10000;
    return m;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; t_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_chain();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present m until the selected instance shows t_ready, then let one edge accept it.
  task automatic feed(input mat_t m, input int sel);
    int n = 0;
    t_matrix = m;
    t_valid  = 1'b1;
    while (!(sel == 4 ? r4 : r2) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("feed_ready", sel == 4 ? r4 : r2, 1'b1);
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    t_valid = 1'b0;
  endtask

  task automatic wait_done(input int sel);
    int n = 0;
    while (!(sel == 4 ? d4 : d2) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", sel == 4 ? d4 : d2, 1'b1);
    t_evt = $time;
  endtask

  initial begin
    mat_t m1, m2, exp_m, rot, scl;
    int n, dcount, ok;

    // Reset state
    do_reset();
    chk("rst_ready", r2, 1'b0);
    chk("rst_busy",  b2, 1'b0);
    chk("rst_done",  d2, 1'b0);
    chk("rst_pose",  p2, '0);

    // start with t_valid in IDLE only starts; identity chain timing
    start = 1'b1; t_valid = 1'b1; t_matrix = ident();
    @(negedge clk);
    start = 1'b0;
    chk("start_not_accept", r2, 1'b1);
    chk("start_busy", b2, 1'b1);
    chk("start_pose_ident", p2, ident());
    @(posedge clk);
    t_first = $time;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!r2 && n < 100);
    chk("latency_17", int'((($time - t_first) - 5) / 10), 17);
    @(posedge clk);
    @(negedge clk);
    t_valid = 1'b0;
    wait_done(2);
    chk("done_cycle_35", int'(((t_evt - t_first) - 5) / 10), 35);
    chk("ident_pose", p2, ident());
    chk("busy_in_done", b2, 1'b1);
    @(negedge clk);
    chk("done_one_cycle", d2, 1'b0);
    chk("idle_busy", b2, 1'b0);

    // Translations x=1.0 then y=2.0
    do_reset();
    start_chain();
    m1 = ident(); m1[0][3] = 27'h10000;
    m2 = ident(); m2[1][3] = 27'h20000;
    feed(m1, 2);
    feed(m2, 2);
    wait_done(2);
    exp_m = ident(); exp_m[0][3] = 27'h10000; exp_m[1][3] = 27'h20000;
    chk("translate_pose", p2, exp_m);
    repeat (5) @(negedge clk);
    chk("pose_hold", p2, exp_m);

    // 0.5 * (-1 LSB) = -0.5 LSB floors to -1
    do_reset();
    start_chain();
    m1 = ident(); m1[0][0] = 27'h0008000;
    m2 = ident(); m2[0][0] = 27'h7FFFFFF;
    feed(m1, 2);
    feed(m2, 2);
    wait_done(2);
    exp_m = ident(); exp_m[0][0] = 27'h7FFFFFF;
    chk("floor_shift", p2, exp_m);

    // rotZ(90) four times on the 4-joint instance
    do_reset();
    start_chain();
    rot = '0;
    rot[0][1] = 27'h7FF0000; rot[1][0] = 27'h10000;
    rot[2][2] = 27'h10000;   rot[3][3] = 27'h10000;
    for (int k = 0; k < 4; k++) feed(rot, 4);
    wait_done(4);
    exp_m = ident();
    ok = 1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        int a, e, d;
        a = $signed(p4[i][j]);
        e = $signed(exp_m[i][j]);
        d = (a > e) ? a - e : e - a;
        if (d > 4) ok = 0;
      end
    chk("rot4_within_4lsb", ok, 1);

    // Scale diag 0x1FFFFFF squared: wraps by default, saturates when enabled
    do_reset();
    start_chain();
    scl = '0;
    scl[0][0] = 27'h1FFFFFF; scl[1][1] = 27'h1FFFFFF;
    scl[2][2] = 27'h1FFFFFF; scl[3][3] = 27'h1FFFFFF;
    feed(scl, 2);
    feed(scl, 2);
    wait_done(2);
`ifdef FK_CHAIN_SAT_EN
    chk("scale_sat_00", p2[0][0], 27'h3FFFFFF);
    chk("scale_sat_33", p2[3][3], 27'h3FFFFFF);
    chk("scale_ovf", ovf2, 1'b1);
`else
    chk("scale_wrap_00", p2[0][0], 27'h7FFFC00);
    chk("scale_wrap_33", p2[3][3], 27'h7FFFC00);
    chk("scale_offdiag", p2[0][1], 27'h0);
`endif

    // Reset on the 8th MUL cycle
    do_reset();
    start_chain();
    m1 = ident(); m1[0][3] = 27'h10000;
    feed(m1, 2);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midmul_ready", r2, 1'b0);
    chk("midmul_busy", b2, 1'b0);
    chk("midmul_pose", p2, '0);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (d2) dcount++;
    end
    chk("midmul_no_done", dcount, 0);

    // Stall 50 cycles in WAIT_T with start pulsed while busy
    do_reset();
    start_chain();
    m1 = ident(); m1[0][3] = 27'h10000;
    m2 = ident(); m2[1][3] = 27'h20000;
    feed(m1, 2);
    n = 0;
    while (!r2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int c = 0; c < 50; c++) begin
      start = (c == 20);
      @(negedge clk);
    end
    start = 1'b0;
    chk("stall_ready", r2, 1'b1);
    chk("stall_busy", b2, 1'b1);
    chk("stall_pose", p2, m1);
    feed(m2, 2);
    wait_done(2);
    exp_m = ident(); exp_m[0][3] = 27'h10000; exp_m[1][3] = 27'h20000;
    chk("stall_final_pose", p2, exp_m);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fk_chain.md
FK_CHAIN -- requirements
Module: fk_chain

Interface
REQ-001 SHALL have parameter N_JOINTS, default 6, meaning the number of T matrices composed per chain (range 1..15).
REQ-002 SHALL have parameter FRAC_BITS, default 16, meaning the fractional bits of every 27-bit signed two's-complement element.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: begin a new chain.
REQ-006 SHALL have port t_valid, input, 1 bit: t_matrix holds a valid joint transform.
REQ-007 SHALL have port t_ready, output, 1 bit: block accepts t_matrix this cycle.
REQ-008 SHALL have port t_matrix, input, [3:0][3:0][26:0]: incoming joint transform, indexed [row][col], produced by t_block.
REQ-009 SHALL have port busy, output, 1 bit: chain in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse, pose is complete.
REQ-011 SHALL have port pose, output, [3:0][3:0][26:0]: accumulated product T1*T2*...*TN.
REQ-012 SHALL have port ovf, output, 1 bit: sticky overflow flag for the current chain (present only with FK_CHAIN_SAT_EN).

Function
REQ-013 SHALL implement states IDLE, WAIT_T, MUL, DONE.
REQ-014 IDLE: start=1 SHALL load accumulator A with identity (diagonal 1<<FRAC_BITS, rest 0), clear the joint counter, clear ovf, and go to WAIT_T; start in any other state SHALL be ignored.
REQ-015 WAIT_T: t_ready SHALL be 1 only in this state; t_valid&t_ready SHALL latch t_matrix into B and go to MUL.
REQ-016 WAIT_T with t_valid=0 SHALL hold state indefinitely with A unchanged.
REQ-017 MUL SHALL compute one element C[i][j] = sum_k A[i][k]*B[k][j] per cycle, row-major order (0,0),(0,1)..(3,3), 16 cycles total.
REQ-018 Each product SHALL be full 54-bit precision; the 4-term sum SHALL be kept at 56 bits, then arithmetic-shifted right by FRAC_BITS (truncation toward minus infinity) before narrowing to 27 bits.
REQ-019 The cycle after the 16th MUL cycle, A SHALL take C and the joint counter SHALL increment; go to WAIT_T if counter < N_JOINTS, else DONE.
REQ-020 Accept-to-next-t_ready latency SHALL be exactly 17 cycles.
REQ-021 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-022 pose SHALL equal A at all times; after DONE it SHALL hold until the next accepted start.
REQ-023 busy SHALL be 1 in WAIT_T, MUL, DONE; 0 in IDLE.
REQ-024 start and t_valid asserted together in IDLE SHALL only start the chain; the matrix SHALL NOT be accepted that cycle.

Reset
REQ-025 reset=1 at a clock edge SHALL force IDLE, t_ready=0, busy=0, done=0, ovf=0, pose=0, counter=0, regardless of state.
REQ-026 reset mid-MUL SHALL discard partial C; no done pulse SHALL follow.

Configuration
REQ-027 Macro FK_CHAIN_SAT_EN defined: narrowing SHALL saturate to +(2^26-1)/-(2^26) and any saturation SHALL set ovf until the next start or reset.
REQ-028 Macro FK_CHAIN_SAT_EN undefined: narrowing SHALL keep the low 27 bits (wrap), and port ovf SHALL be absent.

Structure
REQ-029 Package fk_pkg SHALL hold ELEM_W=27, typedef mat4_t ([3:0][3:0] signed 27-bit), the identity-matrix function of FRAC_BITS, and the state enum.
REQ-030 Sub-module fk_dot4 SHALL be the combinational 4-term dot product with shift and saturate/wrap narrowing, instantiated once.

Verification
REQ-031 N_JOINTS=2, both T=identity -> done 35 cycles after first accept (2x17 + 1), pose=identity.
REQ-032 T1=translate(x=1.0), T2=translate(y=2.0) (0x10000, 0x20000) -> pose[0][3]=0x10000, pose[1][3]=0x20000, rotation identity.
REQ-033 T=rotZ(90 deg) applied 4 times with N_JOINTS=4 -> pose within 4 LSB of identity.
REQ-034 With FK_CHAIN_SAT_EN, diag 0x3FFFFFF/2 scale matrix twice -> element = 0x3FFFFFF, ovf=1; without it -> wrapped value, no ovf.
REQ-035 reset asserted on the 8th MUL cycle -> next cycle t_ready=0, busy=0, pose=0, no done.
REQ-036 t_valid withheld 50 cycles in WAIT_T, start pulsed while busy -> state/A unchanged, chain completes normally once t_valid returns.
